// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes format, immediate and PC-relative
// target on push and holds the results in a 2-entry FIFO toward execute.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    state_t state, state_next;
    logic head, tail;
    logic push, pop;

    logic [XLEN-1:0] imm_q    [2];
    logic [XLEN-1:0] pc_q     [2];
    logic [XLEN-1:0] target_q [2];
    logic [2:0]      fmt_q    [2];
    logic            illegal_q[2];

    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;

    always_comb begin
        dec_fmt     = FMT_ILL;
        dec_illegal = 1'b1;
        case (in_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I; dec_illegal = 1'b0;
            end
            7'b0011011: if (XLEN == 64) begin
                dec_fmt = FMT_I; dec_illegal = 1'b0;
            end
            7'b0100011: begin dec_fmt = FMT_S; dec_illegal = 1'b0; end
            7'b1100011: begin dec_fmt = FMT_B; dec_illegal = 1'b0; end
            7'b0110111, 7'b0010111: begin dec_fmt = FMT_U; dec_illegal = 1'b0; end
            7'b1101111: begin dec_fmt = FMT_J; dec_illegal = 1'b0; end
            7'b0110011: begin dec_fmt = FMT_R; dec_illegal = 1'b0; end
            7'b0111011: if (XLEN == 64) begin
                dec_fmt = FMT_R; dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Build a 32-bit immediate first, then sign-extend to the datapath width.
    always_comb begin
        imm32 = 32'd0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: imm32 = {in_inst[31:12], 12'd0};
            FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
        dec_imm    = XLEN'($signed(imm32));
        dec_target = in_pc + dec_imm;
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) state_next = ONE;
                ONE: begin
                    if (push && !pop) state_next = FULL;
                    else if (pop && !push) state_next = EMPTY;
                end
                FULL:  if (pop) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= 1'b0;
            tail <= 1'b0;
        end else if (flush) begin
            head <= 1'b0;
            tail <= 1'b0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
        end
    end

    // A flushed push is dropped, so its data is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                imm_q[i]     <= '0;
                pc_q[i]      <= '0;
                target_q[i]  <= '0;
                fmt_q[i]     <= 3'd0;
                illegal_q[i] <= 1'b0;
            end
        end else if (push && !flush) begin
            imm_q[tail]     <= dec_imm;
            pc_q[tail]      <= in_pc;
            target_q[tail]  <= dec_target;
            fmt_q[tail]     <= dec_fmt;
            illegal_q[tail] <= dec_illegal;
        end
    end

    assign out_imm     = imm_q[head];
    assign out_pc      = pc_q[head];
    assign out_target  = target_q[head];
    assign out_fmt     = fmt_q[head];
    assign out_illegal = illegal_q[head];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are compared against an arithmetic reference model with a FIFO scoreboard.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_target32, out_pc32;
    logic [2:0]  out_fmt32;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64, out_target64, out_pc64;
    logic [2:0]  out_fmt64;

    int vectors;
    int miscompares;

    logic [31:0] q_inst[$];
    logic [63:0] q_pc[$];

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_target(out_target32), .out_pc(out_pc32),
        .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_target(out_target64), .out_pc(out_pc64),
        .out_illegal(out_illegal64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] ref_fmt(logic [31:0] inst, int xlen);
        case (inst[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
            7'h1B: return (xlen == 64) ? 3'd1 : 3'd7;
            7'h23: return 3'd2;
            7'h63: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            7'h6F: return 3'd5;
            7'h33: return 3'd0;
            7'h3B: return (xlen == 64) ? 3'd0 : 3'd7;
            default: return 3'd7;
        endcase
    endfunction

    // Immediates from signed arithmetic on the whole word: shifts and scaled fields.
    function automatic logic [63:0] ref_imm(logic [31:0] inst, int xlen);
        longint s;
        longint r;
        s = longint'($signed(inst));
        case (ref_fmt(inst, xlen))
            3'd1: r = s >>> 20;
            3'd2: r = (s >>> 25) * 32 + longint'(inst[11:7]);
            3'd3: r = (s >>> 31) * 4096 + longint'(inst[7]) * 2048
                      + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
            3'd4: r = s - (s & 64'sd4095);
            3'd5: r = (s >>> 31) * 1048576 + longint'(inst[19:12]) * 4096
                      + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        logic [63:0] e_imm;
        logic [63:0] e_pc;
        logic [2:0]  f;
        cmp("in_ready32", {63'd0, in_ready32}, {63'd0, q_inst.size() != 2});
        cmp("in_ready64", {63'd0, in_ready64}, {63'd0, q_inst.size() != 2});
        cmp("out_valid32", {63'd0, out_valid32}, {63'd0, q_inst.size() != 0});
        cmp("out_valid64", {63'd0, out_valid64}, {63'd0, q_inst.size() != 0});
        if (q_inst.size() != 0) begin
            e_pc  = q_pc[0];
            e_imm = ref_imm(q_inst[0], 32);
            f     = ref_fmt(q_inst[0], 32);
            cmp("imm32", {32'd0, out_imm32}, {32'd0, e_imm[31:0]});
            cmp("fmt32", {61'd0, out_fmt32}, {61'd0, f});
            cmp("illegal32", {63'd0, out_illegal32}, {63'd0, f == 3'd7});
            cmp("pc32", {32'd0, out_pc32}, {32'd0, e_pc[31:0]});
            e_pc = e_pc + e_imm;
            cmp("target32", {32'd0, out_target32}, {32'd0, e_pc[31:0]});
            e_imm = ref_imm(q_inst[0], 64);
            f     = ref_fmt(q_inst[0], 64);
            cmp("imm64", out_imm64, e_imm);
            cmp("fmt64", {61'd0, out_fmt64}, {61'd0, f});
            cmp("illegal64", {63'd0, out_illegal64}, {63'd0, f == 3'd7});
            cmp("pc64", out_pc64, q_pc[0]);
            cmp("target64", out_target64, q_pc[0] + e_imm);
        end
    endtask

    // One cycle: drive at the falling edge, check registered outputs, then advance the model.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                                 input logic ordy, input logic fl);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        do_push   = v && (q_inst.size() < 2);
        do_pop    = ordy && (q_inst.size() > 0);
        #1;
        checkOutput();
        @(posedge clk);
        if (fl) begin
            q_inst.delete();
            q_pc.delete();
        end else begin
            if (do_pop) begin
                void'(q_inst.pop_front());
                void'(q_pc.pop_front());
            end
            if (do_push) begin
                q_inst.push_back(inst);
                q_pc.push_back(pc);
            end
        end
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, "_in_ready"}, {62'd0, in_ready32, in_ready64}, 64'd3);
        cmp({tag, "_out_valid"}, {62'd0, out_valid32, out_valid64}, 64'd0);
        cmp({tag, "_imm"}, out_imm64 | {32'd0, out_imm32}, 64'd0);
        cmp({tag, "_target"}, out_target64 | {32'd0, out_target32}, 64'd0);
        cmp({tag, "_pc"}, out_pc64 | {32'd0, out_pc32}, 64'd0);
        cmp({tag, "_fmt_ill"}, {58'd0, out_fmt32, out_fmt64} | {62'd0, out_illegal32, out_illegal64}, 64'd0);
    endtask

    logic [6:0]  opcodes [14];
    logic [31:0] r;

    initial begin
        vectors     = 0;
        miscompares = 0;
        opcodes = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63,
                    7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed decode cases with absolute expected values.
        applyStimulus(1'b1, 32'hFFF00093, 64'h0, 1'b1, 1'b0);
        cmp("addi_imm", {32'd0, out_imm32}, 64'hFFFFFFFF);
        cmp("addi_fmt", {61'd0, out_fmt32}, 64'd1);
        applyStimulus(1'b1, 32'hFE112E23, 64'h40, 1'b1, 1'b0);
        cmp("sw_imm", {32'd0, out_imm32}, 64'hFFFFFFFC);
        cmp("sw_fmt", {61'd0, out_fmt32}, 64'd2);
        applyStimulus(1'b1, 32'hFE000CE3, 64'h100, 1'b1, 1'b0);
        cmp("beq_imm", {32'd0, out_imm32}, 64'hFFFFFFF8);
        cmp("beq_target", {32'd0, out_target32}, 64'hF8);
        applyStimulus(1'b1, 32'h123452B7, 64'h200, 1'b1, 1'b0);
        cmp("lui_imm", {32'd0, out_imm32}, 64'h12345000);
        applyStimulus(1'b1, 32'h800002B7, 64'h204, 1'b1, 1'b0);
        cmp("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
        applyStimulus(1'b1, 32'h0000007F, 64'h208, 1'b1, 1'b0);
        cmp("ill_fmt_ill", {60'd0, out_fmt32, out_illegal32}, 64'hF);
        cmp("ill_imm", {32'd0, out_imm32}, 64'd0);
        applyStimulus(1'b1, 32'h0010009B, 64'h20C, 1'b1, 1'b0);
        cmp("addiw32_fmt", {61'd0, out_fmt32}, 64'd7);
        cmp("addiw64_imm", out_imm64, 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Backpressure: A, B accepted, C held until the consumer drains.
        applyStimulus(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200113, 64'h304, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00300193, 64'h308, 1'b0, 1'b0);
        cmp("bp_in_ready", {63'd0, in_ready32}, 64'd0);
        applyStimulus(1'b1, 32'h00300193, 64'h308, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00300193, 64'h308, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        cmp("bp_drained", {62'd0, out_valid32, out_valid64}, 64'd0);

        // Flush while full with a simultaneous push.
        applyStimulus(1'b1, 32'hFE000CE3, 64'h400, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000006F, 64'h404, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h123452B7, 64'h408, 1'b1, 1'b1);
        cmp("flush_state", {60'd0, out_valid32, out_valid64, in_ready32, in_ready64}, 64'h3);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            r = $urandom();
            applyStimulus(($urandom_range(0, 3) != 0), {r[31:7], opcodes[$urandom_range(0, 13)]},
                          {$urandom(), $urandom()}, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-stream with the buffer full.
        applyStimulus(1'b1, 32'hFFF00093, 64'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFE112E23, 64'h504, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkReset("async_rst");
        q_inst.delete();
        q_pc.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0000006F, 64'h600, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
